// File: rtl/ex_muldiv_if.sv
// ID/EX-side mul/div operand bundle and HI/LO result bundle.
// The master side is the pipeline (ID/EX register and HI/LO consumer); the slave side is the mul/div unit.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       id_opcode;
  logic [5:0]       id_func;
  logic [1:0]       id_hilo_we;
  logic [WIDTH-1:0] id_rdata1;
  logic [WIDTH-1:0] id_rdata2;
  logic             int_flush;
  logic             exe_stall;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output id_opcode, id_func, id_hilo_we, id_rdata1, id_rdata2, int_flush,
    input  exe_stall, busy, result_valid, hi, lo
  );

  modport slave (
    input  id_opcode, id_func, id_hilo_we, id_rdata1, id_rdata2, int_flush,
    output exe_stall, busy, result_valid, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO; 33 stall cycles, result in the 34th.
// Holds ID/EX through exe_stall. MULDIV_FAST_MUL_EN makes multiplies complete in a single cycle.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic       clk,
  input  logic       resetn,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] work_q;
  logic [WIDTH-1:0]   mop_q;
  logic               neg_res_q, dvd_neg_q, div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, rv_q;

  logic               start_op, start, is_div, is_uns, rs_neg, rt_neg, last;
  logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
  logic [WIDTH:0]     add, shl, diff;
  logic [2*WIDTH-1:0] mul_step, div_step, mul_fix;

  // func 0x18..0x1B: bit1 selects divide, bit0 selects unsigned
  assign start_op = (bus.id_opcode == 6'h00) && (bus.id_hilo_we == 2'b11) &&
                    (bus.id_func[5:2] == 4'b0110);
  assign is_div   = bus.id_func[1];
  assign is_uns   = bus.id_func[0];
  assign start    = (state_q == IDLE) && start_op && !bus.int_flush;
  assign last     = (cnt_q == CW'(ITER - 1));

  assign rs_neg = !is_uns && bus.id_rdata1[WIDTH-1];
  assign rt_neg = !is_uns && bus.id_rdata2[WIDTH-1];
  assign a_abs  = rs_neg ? -bus.id_rdata1 : bus.id_rdata1;
  assign b_abs  = rt_neg ? -bus.id_rdata2 : bus.id_rdata2;

  // work_q = {accumulator/remainder, multiplier/quotient}; mop_q = multiplicand/divisor
  always_comb begin
    add      = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, mop_q} : '0);
    mul_step = {add, work_q[WIDTH-1:1]};
    shl      = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    diff     = shl - {1'b0, mop_q};
    div_step = diff[WIDTH] ? {shl[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    mul_fix  = neg_res_q ? -mul_step : mul_step;
    // a zero divisor leaves the all-ones quotient unsigned-looking
    quo_fix  = (neg_res_q && !div_zero_q) ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
    rem_fix  = dvd_neg_q ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod, fast_fix;
  assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
  assign fast_fix  = (rs_neg ^ rt_neg) ? -fast_prod : fast_prod;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_FAST_MUL_EN
          state_d = is_div ? DIV : DONE;
`else
          state_d = is_div ? DIV : MUL;
`endif
        end
      end
      MUL, DIV: begin
        if (bus.int_flush) state_d = IDLE;
        else if (last)     state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      mop_q      <= '0;
      neg_res_q  <= 1'b0;
      dvd_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == MUL) || (state_d == DIV);
      rv_q    <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q      <= '0;
            neg_res_q  <= rs_neg ^ rt_neg;
            dvd_neg_q  <= rs_neg;
            div_zero_q <= (bus.id_rdata2 == '0);
            if (is_div) begin
              work_q <= {{WIDTH{1'b0}}, a_abs};
              mop_q  <= b_abs;
            end else begin
              work_q <= {{WIDTH{1'b0}}, b_abs};
              mop_q  <= a_abs;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div) {hi_q, lo_q} <= fast_fix;
`endif
          end
        end
        MUL, DIV: begin
          if (!bus.int_flush) begin
            work_q <= (state_q == MUL) ? mul_step : div_step;
            cnt_q  <= cnt_q + 1'b1;
            if (last) begin
              if (state_q == MUL) begin
                {hi_q, lo_q} <= mul_fix;
              end else begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.exe_stall    = start || (state_q == MUL) || (state_q == DIV);
  assign bus.busy         = busy_q;
  assign bus.result_valid = rv_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: vector table through a scoreboard, plus flush/reset/idle-flush sequences.
module tb_ex_muldiv;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_ST = 1;
`else
  localparam int MUL_ST = 33;
`endif
  localparam int DIV_ST = 33;
  localparam int NV     = 13;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_exp;

  typedef struct {
    logic [5:0]  func;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] exp;
    int          stalls;
  } vec_t;
  vec_t vecs[NV];

  ex_muldiv_if #(.WIDTH(32)) bus();
  ex_muldiv #(.WIDTH(32), .ITER(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, test did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic md, input logic [5:0] func, input logic [31:0] a, input logic [31:0] b);
    bus.id_opcode  = 6'h00;
    bus.id_hilo_we = md ? 2'b11 : 2'b00;
    bus.id_func    = func;
    bus.id_rdata1  = a;
    bus.id_rdata2  = b;
  endtask

  // Called in the low clock phase; returns in the low phase of the cycle after DONE.
  task automatic do_op(input vec_t v, input string tag);
    int          stalls = 0;
    logic        rv_seen = 1'b0;
    logic [63:0] exp;
    sb_q.push_back(v.exp);
    drive(1'b1, v.func, v.rs, v.rt);
    #1;
    while (bus.exe_stall && stalls < 200) begin
      stalls++;
      if (bus.result_valid) rv_seen = 1'b1;
      if (stalls == 2) check({tag, " busy_in_flight"}, 64'(bus.busy), 64'd1);
      @(negedge clk); #1;
    end
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check({tag, " stall_cycles"}, 64'(stalls), 64'(v.stalls));
    check({tag, " no_valid_while_stalled"}, 64'(rv_seen), 64'd0);
    check({tag, " result_valid"}, 64'(bus.result_valid), 64'd1);
    check({tag, " busy_done"}, 64'(bus.busy), 64'd0);
    exp = sb_q.pop_front();
    check({tag, " hilo"}, {bus.hi, bus.lo}, exp);
    @(negedge clk); #1;
    check({tag, " valid_one_cycle"}, 64'(bus.result_valid), 64'd0);
  endtask

  initial begin
    vec_t mu;
    logic rv_seen;

    vecs[0]  = '{F_DIVU,  32'd100,        32'd7,          {32'd2,        32'd14},        DIV_ST};
    vecs[1]  = '{F_DIV,   32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},  DIV_ST};
    vecs[2]  = '{F_DIVU,  32'h00001234,   32'd0,          {32'h00001234, 32'hFFFFFFFF},  DIV_ST};
    vecs[3]  = '{F_DIV,   32'hFFFFFFF9,   32'd0,          {32'hFFFFFFF9, 32'hFFFFFFFF},  DIV_ST};
    vecs[4]  = '{F_DIV,   32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000},  DIV_ST};
    vecs[5]  = '{F_DIV,   32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD},  DIV_ST};
    vecs[6]  = '{F_DIV,   32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'h00000003},  DIV_ST};
    vecs[7]  = '{F_DIVU,  32'hFFFFFFFF,   32'd10,         {32'h00000005, 32'h19999999},  DIV_ST};
    vecs[8]  = '{F_MULT,  32'hFFFFFFFF,   32'd3,          {32'hFFFFFFFF, 32'hFFFFFFFD},  MUL_ST};
    vecs[9]  = '{F_MULT,  32'd7,          32'hFFFFFFFA,   {32'hFFFFFFFF, 32'hFFFFFFD6},  MUL_ST};
    vecs[10] = '{F_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'hFFFFFFFE, 32'h00000001},  MUL_ST};
    vecs[11] = '{F_MULTU, 32'h00010000,   32'h00010000,   {32'h00000001, 32'h00000000},  MUL_ST};
    vecs[12] = '{F_MULT,  32'h80000000,   32'h80000000,   {32'h40000000, 32'h00000000},  MUL_ST};
    last_exp = vecs[NV-1].exp;

    drive(1'b0, 6'h00, 32'h0, 32'h0);
    bus.int_flush = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset exe_stall", 64'(bus.exe_stall), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset result_valid", 64'(bus.result_valid), 64'd0);

    // Non-mul/div func with hilo_we=11 must not start anything
    drive(1'b1, 6'h10, 32'd5, 32'd6);
    #1;
    check("other_func no stall", 64'(bus.exe_stall), 64'd0);
    @(negedge clk); #1;
    check("other_func no busy", 64'(bus.busy), 64'd0);
    drive(1'b0, 6'h00, 32'h0, 32'h0);

    // Back-to-back: each op enters the cycle after the previous DONE
    for (int i = 0; i < NV; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Flush arriving in the start cycle suppresses the start
    drive(1'b1, F_MULT, 32'd3, 32'd4);
    bus.int_flush = 1'b1;
    #1;
    check("idle_flush exe_stall", 64'(bus.exe_stall), 64'd0);
    @(negedge clk); #1;
    bus.int_flush = 1'b0;
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    check("idle_flush busy", 64'(bus.busy), 64'd0);
    check("idle_flush hilo", {bus.hi, bus.lo}, last_exp);

    // Flush at iteration 10 of a divide
    drive(1'b1, F_DIV, 32'd100, 32'd7);
    #1;
    check("flush start stall", 64'(bus.exe_stall), 64'd1);
    repeat (11) begin @(negedge clk); #1; end
    bus.int_flush = 1'b1;
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    #1;
    check("flush cycle stall", 64'(bus.exe_stall), 64'd1);
    @(negedge clk); #1;
    bus.int_flush = 1'b0;
    check("after flush stall", 64'(bus.exe_stall), 64'd0);
    check("after flush busy", 64'(bus.busy), 64'd0);
    check("after flush hilo held", {bus.hi, bus.lo}, last_exp);
    rv_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.result_valid) rv_seen = 1'b1;
      @(negedge clk); #1;
    end
    check("after flush no result_valid", 64'(rv_seen), 64'd0);

    // Reset at iteration 10 of a divide
    drive(1'b1, F_DIV, 32'hFFFFFFF9, 32'd2);
    #1;
    repeat (11) begin @(negedge clk); #1; end
    resetn = 1'b0;
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    @(negedge clk); #1;
    check("midop reset hilo", {bus.hi, bus.lo}, 64'd0);
    check("midop reset busy", 64'(bus.busy), 64'd0);
    check("midop reset stall", 64'(bus.exe_stall), 64'd0);
    check("midop reset result_valid", 64'(bus.result_valid), 64'd0);
    resetn = 1'b1;
    @(negedge clk); #1;

    mu = '{F_MULTU, 32'h00010000, 32'h00010000, {32'h00000001, 32'h00000000}, MUL_ST};
    do_op(mu, "post_reset multu");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
